ped_signal_ctrl: RTL and testbench
==================================

# ped_signal_ctrl

Pedestrian signal controller for the four-way intersection. Sits directly downstream of the vehicle traffic-light FSM and consumes its `light_ns` / `light_ew` one-hot lamp codes. Latches pedestrian push-button requests per axis and grants a WALK phase when that axis's vehicle light enters green. Then runs a flashing DON'T WALK countdown and returns to steady DON'T WALK. Also flags illegal lamp combinations as a sticky safety fault.

## Interface
- `WALK_CYCLES`, 8, cycles walk_x is held high (1..63)
- `FLASH_CYCLES`, 6, cycles of flashing don't-walk / countdown (1..63)
- `clk`  input  1  system clock, rising edge
- `rst`  input  1  reset, asynchronous, active-low
- `light_ns`  input  3  NS vehicle lamp: red=3'b100, yellow=3'b010, green=3'b001
- `light_ew`  input  3  EW vehicle lamp, same encoding
- `ped_req_ns`  input  1  NS crossing button, level, sampled every edge
- `ped_req_ew`  input  1  EW crossing button
- `walk_ns`, `walk_ew`  output  1  WALK lamp
- `dont_walk_ns`, `dont_walk_ew`  output  1  DON'T WALK lamp
- `countdown_ns`, `countdown_ew`  output  6  remaining flash cycles, 0 outside FLASH
- `pend_ns`, `pend_ew`  output  1  request latched, not yet served
- `fault`  output  1  sticky illegal-lamp flag

## Operation
- Two identical channels, x ∈ {ns, ew}. Each channel has a 3-state FSM: DONT_WALK, WALK, FLASH.
- Each channel keeps a registered copy `prev_x` of the previous sampled light.
- Green entry on an edge: `light_x==green` and `prev_x!=green`.
- Request latch:
  - pend_x sets on any edge with ped_req_x=1 while in DONT_WALK or FLASH. Requests are ignored in WALK.
  - pend_x clears on the edge that enters WALK.
- DONT_WALK → WALK: green entry and (pend_x or ped_req_x). Counter loads WALK_CYCLES-1.
- DONT_WALK with green entry and no request: stay. The request is not served until the next green entry.
- WALK:
  - Counter decrements each edge.
  - Counter==0 while still green → FLASH, counter loads FLASH_CYCLES.
  - light_x==yellow → FLASH immediately, counter loads FLASH_CYCLES.
  - light_x==red → DONT_WALK immediately.
- FLASH:
  - Counter decrements each edge.
  - Counter==1 → DONT_WALK.
  - light_x==red → DONT_WALK immediately, countdown forced to 0.
  - Green or yellow: continue.
- Outputs per state:
  - DONT_WALK: walk=0, dont_walk=1, countdown=0.
  - WALK: walk=1, dont_walk=0, countdown=0.
  - FLASH: walk=0, countdown=counter, dont_walk=counter[0]. The lamp blinks and is high on odd values.
- Fault detection:
  - Illegal when either light is not one of the three legal codes, or both lights are non-red in the same cycle.
  - fault sets on the sampling edge and stays set until reset.
  - While fault=1: both channels forced to DONT_WALK, pend_x held at 0, requests ignored.
- Counter arithmetic is 6-bit unsigned. It never wraps, because every exit happens at 0 or 1.

## Timing
- All outputs are registered. Inputs are sampled at the rising clk edge.
- Reset values (async, rst=0):
  - walk_x=0, dont_walk_x=1, countdown_x=0, pend_x=0, fault=0.
  - FSMs in DONT_WALK; prev_x=red (3'b100).
- Green entry sampled at edge k:
  - walk_x=1 from edge k through edge k+WALK_CYCLES-1, i.e. WALK_CYCLES cycles.
  - FLASH for FLASH_CYCLES cycles, countdown FLASH_CYCLES..1.
  - Steady DON'T WALK after that.
- Defaults total 14 cycles. This fits inside the upstream 21-cycle green.
- A request asserted in the same edge as green entry is served that green; pend_x never visibly rises.
- Reset asserted mid-WALK/FLASH: outputs return to reset values immediately, with no waiting for clk.
- Reset release is synchronised by the system; the first post-release edge operates normally.

## Configuration
- `PED_COUNTDOWN_EN` defined: countdown_ns/ew are driven as specified.
- Not defined:
  - countdown_x is tied to 6'd0.
  - The FLASH counter still runs internally; dont_walk blinking and all state timing are unchanged.

## Test plan
- Reset: assert rst=0 mid-run → all outputs at reset values immediately. After release with lights red/red: dont_walk=1, fault=0.
- Served request:
  - Stimulus: ped_req_ns pulse during all-red, then light_ns goes green at edge k.
  - pend_ns=1 until k; walk_ns=1 for 8 cycles.
  - countdown_ns=6,5,4,3,2,1 with dont_walk_ns=0,1,0,1,0,1; then dont_walk_ns=1 steady.
- No request: light_ew green entry with pend_ew=0 → walk_ew stays 0 for the whole green.
- Early yellow:
  - Stimulus: WALK_CYCLES=30, light_ns yellow 20 cycles after green entry.
  - Response: next cycle FLASH with countdown_ns=6. Red arriving at countdown 3 → countdown 0, dont_walk_ns=1.
- Fault: light_ns=3'b011 for one cycle, or both lights green → fault=1 next cycle. Both dont_walk=1, walk=0; stays so through later legal lights until rst.
- Macro off: rerun the served-request scenario → countdown_ns constantly 0, all other outputs identical.

Source files
------------

// File: rtl/ped_signal_ctrl.sv
// Pedestrian WALK / flashing DON'T WALK controller slaved to the vehicle lamp FSM, with sticky illegal-lamp fault.
// Latency: WALK asserts on the same edge that samples vehicle green entry; all outputs decode registered state only.
// Backpressure: none; inputs are sampled every edge. Optional countdown display via `PED_COUNTDOWN_EN`.

// One crossing channel: request latch, DONT_WALK/WALK/FLASH FSM and its phase counter.
module ped_chan #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light,
    input  logic       req,
    input  logic       force_off,
    output logic       walk,
    output logic       dont_walk,
    output logic [5:0] countdown,
    output logic       pend
);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    typedef enum logic [1:0] {
        DONT_WALK = 2'd0,
        WALK      = 2'd1,
        FLASH     = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [5:0] cnt, cnt_nxt;
    logic       pend_q, pend_nxt;
    logic [2:0] prev;
    logic       green_entry;

    // State, counter, request latch and previous-lamp registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DONT_WALK;
            cnt    <= 6'd0;
            pend_q <= 1'b0;
            prev   <= LAMP_RED;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            pend_q <= pend_nxt;
            prev   <= light;
        end
    end

    // Next-state: serve a latched or same-edge request on green entry, shorten
    // WALK on yellow, abort on red; a fault overrides everything.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_nxt    = pend_q;
        green_entry = (light == LAMP_GREEN) && (prev != LAMP_GREEN);

        case (state)
            DONT_WALK: begin
                if (green_entry && (pend_q || req)) begin
                    state_nxt = WALK;
                    cnt_nxt   = 6'(WALK_CYCLES - 1);
                    pend_nxt  = 1'b0;
                end else begin
                    pend_nxt  = pend_q | req;
                end
            end
            WALK: begin
                // Requests arriving while the crossing is already open are dropped.
                if (light == LAMP_RED) begin
                    state_nxt = DONT_WALK;
                    cnt_nxt   = 6'd0;
                end else if (light == LAMP_YELLOW || cnt == 6'd0) begin
                    state_nxt = FLASH;
                    cnt_nxt   = 6'(FLASH_CYCLES);
                end else begin
                    cnt_nxt   = cnt - 6'd1;
                end
            end
            FLASH: begin
                pend_nxt = pend_q | req;
                if (light == LAMP_RED || cnt == 6'd1) begin
                    state_nxt = DONT_WALK;
                    cnt_nxt   = 6'd0;
                end else begin
                    cnt_nxt   = cnt - 6'd1;
                end
            end
            default: begin
                state_nxt = DONT_WALK;
                cnt_nxt   = 6'd0;
            end
        endcase

        if (force_off) begin
            state_nxt = DONT_WALK;
            cnt_nxt   = 6'd0;
            pend_nxt  = 1'b0;
        end
    end

    // Lamp decode from registered state; the flashing lamp is lit on odd counts.
    always_comb begin
        walk      = 1'b0;
        dont_walk = 1'b1;
        countdown = 6'd0;
        pend      = pend_q;
        case (state)
            WALK: begin
                walk      = 1'b1;
                dont_walk = 1'b0;
            end
            FLASH: begin
                dont_walk = cnt[0];
`ifdef PED_COUNTDOWN_EN
                countdown = cnt;
`else
                countdown = 6'd0;
`endif
            end
            default: ;
        endcase
    end

endmodule

// Top: fault monitor over both lamp inputs plus one channel per axis.
module ped_signal_ctrl #(
    parameter int WALK_CYCLES  = 8,
    parameter int FLASH_CYCLES = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] light_ns,
    input  logic [2:0] light_ew,
    input  logic       ped_req_ns,
    input  logic       ped_req_ew,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       dont_walk_ns,
    output logic       dont_walk_ew,
    output logic [5:0] countdown_ns,
    output logic [5:0] countdown_ew,
    output logic       pend_ns,
    output logic       pend_ew,
    output logic       fault
);

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    logic illegal;
    logic fault_nxt;

    function automatic logic lamp_legal(input logic [2:0] l);
        return (l == LAMP_RED) || (l == LAMP_YELLOW) || (l == LAMP_GREEN);
    endfunction

    // Illegal when a lamp code is malformed or both axes show non-red together.
    always_comb begin
        illegal   = !lamp_legal(light_ns) || !lamp_legal(light_ew) ||
                    ((light_ns != LAMP_RED) && (light_ew != LAMP_RED));
        fault_nxt = fault | illegal;
    end

    // Sticky fault flag; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_nxt;
        end
    end

    // Channels are forced off on the same edge the fault is first seen.
    ped_chan #(
        .WALK_CYCLES (WALK_CYCLES),
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_ns (
        .clk      (clk),
        .rst      (rst),
        .light    (light_ns),
        .req      (ped_req_ns),
        .force_off(fault_nxt),
        .walk     (walk_ns),
        .dont_walk(dont_walk_ns),
        .countdown(countdown_ns),
        .pend     (pend_ns)
    );

    ped_chan #(
        .WALK_CYCLES (WALK_CYCLES),
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_ew (
        .clk      (clk),
        .rst      (rst),
        .light    (light_ew),
        .req      (ped_req_ew),
        .force_off(fault_nxt),
        .walk     (walk_ew),
        .dont_walk(dont_walk_ew),
        .countdown(countdown_ew),
        .pend     (pend_ew)
    );

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Directed bench for ped_signal_ctrl: default instance (a) and a WALK_CYCLES=30 instance (b) on shared stimulus.
// Each observation packs {walk, dont_walk, pend, countdown} of one channel.
// Countdown expectations follow `PED_COUNTDOWN_EN` so the same bench covers both builds.
module tb_ped_signal_ctrl;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] light_ns, light_ew;
    logic       ped_req_ns, ped_req_ew;

    logic       a_walk_ns, a_walk_ew, a_dont_walk_ns, a_dont_walk_ew;
    logic [5:0] a_countdown_ns, a_countdown_ew;
    logic       a_pend_ns, a_pend_ew, a_fault;
    logic       b_walk_ns, b_walk_ew, b_dont_walk_ns, b_dont_walk_ew;
    logic [5:0] b_countdown_ns, b_countdown_ew;
    logic       b_pend_ns, b_pend_ew, b_fault;

    int checks   = 0;
    int failures = 0;

    logic [8:0] obs, exp_v;

    always #5 clk = ~clk;

    ped_signal_ctrl u_dut_a (
        .clk(clk), .rst(rst), .light_ns(light_ns), .light_ew(light_ew),
        .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
        .walk_ns(a_walk_ns), .walk_ew(a_walk_ew),
        .dont_walk_ns(a_dont_walk_ns), .dont_walk_ew(a_dont_walk_ew),
        .countdown_ns(a_countdown_ns), .countdown_ew(a_countdown_ew),
        .pend_ns(a_pend_ns), .pend_ew(a_pend_ew), .fault(a_fault)
    );

    ped_signal_ctrl #(.WALK_CYCLES(30), .FLASH_CYCLES(6)) u_dut_b (
        .clk(clk), .rst(rst), .light_ns(light_ns), .light_ew(light_ew),
        .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
        .walk_ns(b_walk_ns), .walk_ew(b_walk_ew),
        .dont_walk_ns(b_dont_walk_ns), .dont_walk_ew(b_dont_walk_ew),
        .countdown_ns(b_countdown_ns), .countdown_ew(b_countdown_ew),
        .pend_ns(b_pend_ns), .pend_ew(b_pend_ew), .fault(b_fault)
    );

    function automatic logic [5:0] cd(input int n);
`ifdef PED_COUNTDOWN_EN
        return 6'(n);
`else
        return (n == 0) ? 6'd0 : 6'd0;
`endif
    endfunction

    function automatic logic [8:0] ex(input logic w, input logic d, input logic p, input int c);
        return {w, d, p, cd(c)};
    endfunction

    function automatic logic [8:0] a_ns();
        return {a_walk_ns, a_dont_walk_ns, a_pend_ns, a_countdown_ns};
    endfunction
    function automatic logic [8:0] a_ew();
        return {a_walk_ew, a_dont_walk_ew, a_pend_ew, a_countdown_ew};
    endfunction
    function automatic logic [8:0] b_ns();
        return {b_walk_ns, b_dont_walk_ns, b_pend_ns, b_countdown_ns};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; light_ns = RED; light_ew = RED; ped_req_ns = 1'b0; ped_req_ew = 1'b0;
        #12;
        obs = a_ns(); exp_v = ex(0, 1, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_ns got=%b exp=%b", obs, exp_v); end
        obs = a_ew(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL reset_ew got=%b exp=%b", obs, exp_v); end
        checks++;
        if (a_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%b exp=0", a_fault); end
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({a_dont_walk_ns, a_dont_walk_ew, a_fault} !== 3'b110) begin
            failures++; $display("FAIL post_release got=%b exp=110", {a_dont_walk_ns, a_dont_walk_ew, a_fault});
        end
    endtask

    task automatic test_served_request();
        ped_req_ns = 1'b1; tick(); ped_req_ns = 1'b0;
        obs = a_ns(); exp_v = ex(0, 1, 1, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_set got=%b exp=%b", obs, exp_v); end
        tick();
        obs = a_ns(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pend_hold got=%b exp=%b", obs, exp_v); end
        light_ns = GREEN; tick();
        obs = a_ns(); exp_v = ex(1, 0, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL walk_entry got=%b exp=%b", obs, exp_v); end
        for (int i = 1; i < 8; i++) begin
            ped_req_ns = (i == 3);
            tick();
            obs = a_ns(); checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL walk_hold[%0d] got=%b exp=%b", i, obs, exp_v); end
        end
        ped_req_ns = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            obs = a_ns(); exp_v = ex(0, ((6 - i) % 2) == 1, 0, 6 - i); checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL flash[%0d] got=%b exp=%b", 6 - i, obs, exp_v); end
        end
        tick();
        obs = a_ns(); exp_v = ex(0, 1, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL flash_done got=%b exp=%b", obs, exp_v); end
        obs = a_ew(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL ew_idle got=%b exp=%b", obs, exp_v); end
        light_ns = YELLOW; tick(); tick();
        light_ns = RED; tick(); tick();
        obs = a_ns(); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL served_end got=%b exp=%b", obs, exp_v); end
    endtask

    task automatic test_no_request();
        light_ew = GREEN;
        for (int i = 0; i < 21; i++) begin
            ped_req_ew = (i == 10);
            tick();
            obs = a_ew(); exp_v = ex(0, 1, i >= 10, 0); checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL no_req_green[%0d] got=%b exp=%b", i, obs, exp_v); end
        end
        ped_req_ew = 1'b0;
        light_ew = YELLOW; tick(); tick();
        light_ew = RED; tick(); tick();
        light_ew = GREEN; tick();
        obs = a_ew(); exp_v = ex(1, 0, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL next_green_served got=%b exp=%b", obs, exp_v); end
        light_ew = RED; tick();
        obs = a_ew(); exp_v = ex(0, 1, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL red_in_walk got=%b exp=%b", obs, exp_v); end
        tick();
    endtask

    task automatic test_same_edge();
        ped_req_ns = 1'b1; light_ns = GREEN; tick(); ped_req_ns = 1'b0;
        obs = a_ns(); exp_v = ex(1, 0, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL same_edge_walk got=%b exp=%b", obs, exp_v); end
        light_ns = YELLOW; tick();
        obs = a_ns(); exp_v = ex(0, 0, 0, 6); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL yellow_in_walk got=%b exp=%b", obs, exp_v); end
        light_ns = RED; tick();
        obs = a_ns(); exp_v = ex(0, 1, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL red_in_flash got=%b exp=%b", obs, exp_v); end
        tick();
    endtask

    task automatic test_early_yellow();
        ped_req_ns = 1'b1; light_ns = GREEN; tick(); ped_req_ns = 1'b0;
        exp_v = ex(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            obs = b_ns(); checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL long_walk[%0d] got=%b exp=%b", i, obs, exp_v); end
            if (i < 19) tick();
        end
        light_ns = YELLOW;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = b_ns(); exp_v = ex(0, ((6 - i) % 2) == 1, 0, 6 - i); checks++;
            if (obs !== exp_v) begin failures++; $display("FAIL early_yellow[%0d] got=%b exp=%b", 6 - i, obs, exp_v); end
        end
        checks++;
        if (a_dont_walk_ns !== 1'b1) begin failures++; $display("FAIL short_walk_done got=%b exp=1", a_dont_walk_ns); end
        light_ns = RED; tick();
        obs = b_ns(); exp_v = ex(0, 1, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL red_at_3 got=%b exp=%b", obs, exp_v); end
        tick();
    endtask

    task automatic test_reset_midrun();
        ped_req_ns = 1'b1; light_ns = GREEN; tick(); ped_req_ns = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        obs = a_ns(); exp_v = ex(0, 1, 0, 5); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL pre_reset_flash got=%b exp=%b", obs, exp_v); end
        #3 rst = 1'b0;
        #1;
        obs = a_ns(); exp_v = ex(0, 1, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL async_reset got=%b exp=%b", obs, exp_v); end
        light_ns = RED;
        #3 rst = 1'b1;
        light_ns = GREEN; ped_req_ns = 1'b1; tick(); ped_req_ns = 1'b0;
        obs = a_ns(); exp_v = ex(1, 0, 0, 0); checks++;
        if (obs !== exp_v) begin failures++; $display("FAIL first_edge_after_reset got=%b exp=%b", obs, exp_v); end
        light_ns = RED; tick();
    endtask

    task automatic test_fault();
        ped_req_ns = 1'b1; light_ns = GREEN; tick(); ped_req_ns = 1'b0; tick();
        light_ns = 3'b011; tick();
        checks++;
        if ({a_fault, a_walk_ns, a_dont_walk_ns, a_dont_walk_ew, a_pend_ns, a_countdown_ns} !== {5'b10110, 6'd0}) begin
            failures++;
            $display("FAIL fault_bad_code got=%b exp=%b",
                     {a_fault, a_walk_ns, a_dont_walk_ns, a_dont_walk_ew, a_pend_ns, a_countdown_ns}, {5'b10110, 6'd0});
        end
        light_ns = GREEN; ped_req_ns = 1'b1; ped_req_ew = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({a_fault, a_walk_ns, a_walk_ew, a_dont_walk_ns, a_dont_walk_ew, a_pend_ns, a_pend_ew} !== 7'b1001100) begin
                failures++;
                $display("FAIL fault_sticky[%0d] got=%b exp=1001100", i,
                         {a_fault, a_walk_ns, a_walk_ew, a_dont_walk_ns, a_dont_walk_ew, a_pend_ns, a_pend_ew});
            end
        end
        ped_req_ns = 1'b0; ped_req_ew = 1'b0;
        rst = 1'b0; #2;
        checks++;
        if ({a_fault, b_fault} !== 2'b00) begin failures++; $display("FAIL fault_cleared got=%b exp=00", {a_fault, b_fault}); end
        light_ns = RED; light_ew = RED;
        #2 rst = 1'b1;
        tick();
        ped_req_ns = 1'b1; light_ns = GREEN; light_ew = GREEN; tick();
        checks++;
        if ({a_fault, a_walk_ns, a_dont_walk_ns, a_dont_walk_ew, a_pend_ns} !== 5'b10110) begin
            failures++;
            $display("FAIL fault_both_green got=%b exp=10110", {a_fault, a_walk_ns, a_dont_walk_ns, a_dont_walk_ew, a_pend_ns});
        end
        ped_req_ns = 1'b0; light_ew = RED;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({a_fault, a_walk_ns, a_dont_walk_ns, a_dont_walk_ew} !== 4'b1011) begin
                failures++;
                $display("FAIL fault_hold[%0d] got=%b exp=1011", i, {a_fault, a_walk_ns, a_dont_walk_ns, a_dont_walk_ew});
            end
        end
        rst = 1'b0; light_ns = RED; #2 rst = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_served_request();
        test_no_request();
        test_same_edge();
        test_early_yellow();
        test_reset_midrun();
        test_fault();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
